// File: rtl/system_bus_router.sv
// system_bus_router: single-master, multi-slave bus fabric.
// Requests are steered combinationally to the slave selected by the top
// address bits. Outstanding reads are remembered in an in-order FIFO of slave
// indices so returning data can be steered back to the master in issue order.
module system_bus_router #(
    parameter int SEL_BITS        = 2,
    parameter int ADDR_WIDTH      = 30,
    parameter int MAX_OUTSTANDING = 4,
    localparam int NUM_SLAVES     = 2 ** SEL_BITS,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    output logic                           o_master_bus_ready,
    input  logic [ADDR_WIDTH-1:0]          i_master_bus_addr,
    input  logic [31:0]                    i_master_bus_write_data,
    input  logic [3:0]                     i_master_bus_byte_enable,
    input  logic                           i_master_bus_write_req,
    input  logic                           i_master_bus_read_req,
    output logic [31:0]                    o_master_bus_read_data,
    output logic                           o_master_bus_read_data_valid,
    input  logic [NUM_SLAVES-1:0]          i_slave_bus_ready,
    output logic [ADDR_WIDTH-SEL_BITS-1:0] o_slave_bus_addr,
    output logic [31:0]                    o_slave_bus_write_data,
    output logic [3:0]                     o_slave_bus_byte_enable,
    output logic [NUM_SLAVES-1:0]          o_slave_bus_write_req,
    output logic [NUM_SLAVES-1:0]          o_slave_bus_read_req,
    input  logic [32*NUM_SLAVES-1:0]       i_slave_bus_read_data,
    input  logic [NUM_SLAVES-1:0]          i_slave_bus_read_data_valid,
    output logic [CNT_W-1:0]               o_outstanding_count,
    output logic                           o_protocol_error
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

    logic [SEL_BITS-1:0]   r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_protocol_error;

    logic [SEL_BITS-1:0]   w_sel;
    logic [SEL_BITS-1:0]   w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_read_blocked;
    logic [NUM_SLAVES-1:0] w_head_mask;
    logic                  w_stray_valid;

    assign w_sel   = i_master_bus_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign w_head  = r_fifo[r_rd_ptr];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // The head's return frees its slot in the same cycle, so a read held
    // against a full FIFO is let through when it coincides with a pop; the
    // pop depends only on slave inputs, so there is no combinational loop.
    assign w_pop          = ~w_empty & i_slave_bus_read_data_valid[w_head];
    assign w_read_blocked = w_full & ~w_pop;

    assign o_master_bus_ready = ~i_reset & i_slave_bus_ready[w_sel]
                              & (~i_master_bus_read_req | ~w_read_blocked);
    assign w_push = i_master_bus_read_req & o_master_bus_ready;

    assign o_slave_bus_addr        = i_master_bus_addr[ADDR_WIDTH-SEL_BITS-1:0];
    assign o_slave_bus_write_data  = i_master_bus_write_data;
    assign o_slave_bus_byte_enable = i_master_bus_byte_enable;

    // Forward the master request to the selected slave only.
    always_comb begin
        o_slave_bus_write_req = '0;
        o_slave_bus_read_req  = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (w_sel == SEL_BITS'(s)) begin
                o_slave_bus_write_req[s] = i_master_bus_write_req & ~i_reset;
                o_slave_bus_read_req[s]  = i_master_bus_read_req & ~w_read_blocked & ~i_reset;
            end
        end
    end

    // Steer read data from the slave at the FIFO head back to the master.
    always_comb begin
        o_master_bus_read_data = '0;
        w_head_mask            = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (w_head == SEL_BITS'(s)) begin
                o_master_bus_read_data = i_slave_bus_read_data[32*s +: 32];
                w_head_mask[s]         = ~w_empty;
            end
        end
    end

    // Any valid not from the current head (or with nothing outstanding) is stray.
    assign w_stray_valid = |(i_slave_bus_read_data_valid & ~w_head_mask);

    assign o_master_bus_read_data_valid = w_pop;
    assign o_outstanding_count          = r_count;
    assign o_protocol_error             = r_protocol_error;

    // Tracking FIFO pointers, occupancy and the sticky protocol error flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_protocol_error <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_protocol_error <= r_protocol_error | w_stray_valid;
        end
    end

endmodule

// File: tb/tb_system_bus_router.sv
// Directed bench for system_bus_router with default parameters
// (4 slaves, 30-bit master address, 4-deep read tracking).
module tb_system_bus_router;

    logic         clk = 1'b0;
    logic         reset;
    logic         ready;
    logic [29:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   be;
    logic         wreq;
    logic         rreq;
    logic [31:0]  rdata;
    logic         rvalid;
    logic [3:0]   s_ready;
    logic [27:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_be;
    logic [3:0]   s_wreq;
    logic [3:0]   s_rreq;
    logic [127:0] s_rdata;
    logic [3:0]   s_rvalid;
    logic [2:0]   count;
    logic         perr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    system_bus_router dut (
        .i_clk                        (clk),
        .i_reset                      (reset),
        .o_master_bus_ready           (ready),
        .i_master_bus_addr            (addr),
        .i_master_bus_write_data      (wdata),
        .i_master_bus_byte_enable     (be),
        .i_master_bus_write_req       (wreq),
        .i_master_bus_read_req        (rreq),
        .o_master_bus_read_data       (rdata),
        .o_master_bus_read_data_valid (rvalid),
        .i_slave_bus_ready            (s_ready),
        .o_slave_bus_addr             (s_addr),
        .o_slave_bus_write_data       (s_wdata),
        .o_slave_bus_byte_enable      (s_be),
        .o_slave_bus_write_req        (s_wreq),
        .o_slave_bus_read_req         (s_rreq),
        .i_slave_bus_read_data        (s_rdata),
        .i_slave_bus_read_data_valid  (s_rvalid),
        .o_outstanding_count          (count),
        .o_protocol_error             (perr)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input logic [1:0] sel, input logic [27:0] off);
        addr = {sel, off};
        rreq = 1'b1;
        wreq = 1'b0;
    endtask

    task automatic slave_return(input int s, input logic [31:0] d);
        s_rvalid = '0;
        s_rvalid[s] = 1'b1;
        s_rdata[32*s +: 32] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_read(2'd0, 28'h10);
        #2;
        checks++; if (s_rreq !== 4'b0000) begin failures++; $display("FAIL reset_rreq: got %b want 0000", s_rreq); end
        checks++; if (s_wreq !== 4'b0000) begin failures++; $display("FAIL reset_wreq: got %b want 0000", s_wreq); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b want 0", perr); end
        rreq = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        set_read(2'd0, 28'h10);
        #1;
        checks++; if (s_rreq !== 4'b0001) begin failures++; $display("FAIL single_rreq: got %b want 0001", s_rreq); end
        checks++; if (s_addr !== 28'h0000010) begin failures++; $display("FAIL single_addr: got %h want 0000010", s_addr); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", ready); end
        tick();
        rreq = 1'b0;
        #1;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1: got %0d want 1", count); end
        tick();
        slave_return(0, 32'hDEADBEEF);
        #1;
        checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", rvalid); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h want deadbeef", rdata); end
        tick();
        s_rvalid = '0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count0: got %0d want 0", count); end
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL single_perr: got %b want 0", perr); end
    endtask

    task automatic test_out_of_order();
        logic [1:0] order [3];
        order[0] = 2'd2; order[1] = 2'd1; order[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            set_read(order[i], 28'h100 + 28'(i));
            tick();
        end
        rreq = 1'b0;
        #1;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL ooo_count: got %0d want 3", count); end
        slave_return(3, 32'h3333_0000);
        #1;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL ooo_early3_valid: got %b want 0", rvalid); end
        tick();
        s_rvalid = '0;
        #1;
        checks++; if (perr !== 1'b1) begin failures++; $display("FAIL ooo_perr: got %b want 1", perr); end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL ooo_nopop: got %0d want 3", count); end
        slave_return(1, 32'h1111_0000);
        #1;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL ooo_early1_valid: got %b want 0", rvalid); end
        tick();
        slave_return(2, 32'h2222_0000);
        #1;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h2222_0000) begin failures++; $display("FAIL ooo_head2: got v=%b d=%h want v=1 d=22220000", rvalid, rdata); end
        tick();
        for (int i = 1; i < 3; i++) begin
            slave_return(int'(order[i]), 32'h5A00_0000 + 32'(order[i]));
            #1;
            checks++; if (rvalid !== 1'b1 || rdata !== 32'h5A00_0000 + 32'(order[i])) begin failures++; $display("FAIL ooo_drain%0d: got v=%b d=%h", i, rvalid, rdata); end
            tick();
        end
        s_rvalid = '0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL ooo_drained: got %0d want 0", count); end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL ooo_perr_cleared: got %b want 0", perr); end
        for (int i = 0; i < 3; i++) begin
            set_read(order[i], 28'h200 + 28'(i));
            tick();
        end
        rreq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            slave_return(int'(order[i]), 32'hC0DE_0000 + 32'(order[i]));
            #1;
            checks++; if (rvalid !== 1'b1 || rdata !== 32'hC0DE_0000 + 32'(order[i])) begin failures++; $display("FAIL inorder%0d: got v=%b d=%h", i, rvalid, rdata); end
            tick();
        end
        s_rvalid = '0;
        #1;
        checks++; if (count !== 3'd0 || perr !== 1'b0) begin failures++; $display("FAIL inorder_end: got count=%0d perr=%b want 0 0", count, perr); end
    endtask

    task automatic test_full_blocks_reads();
        for (int i = 0; i < 4; i++) begin
            set_read(2'(i), 28'h300 + 28'(i));
            tick();
        end
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", count); end
        set_read(2'd2, 28'h400);
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", ready); end
        checks++; if (s_rreq !== 4'b0000) begin failures++; $display("FAIL full_rreq: got %b want 0000", s_rreq); end
        rreq  = 1'b0;
        wreq  = 1'b1;
        addr  = {2'd1, 28'h0000055};
        wdata = 32'h1234_5678;
        #1;
        checks++; if (ready !== 1'b1 || s_wreq !== 4'b0010) begin failures++; $display("FAIL full_write: got ready=%b wreq=%b want 1 0010", ready, s_wreq); end
        tick();
        wreq = 1'b0;
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_after_write: got %0d want 4", count); end
    endtask

    task automatic test_full_push_pop();
        logic [1:0] rest [4];
        rest[0] = 2'd1; rest[1] = 2'd2; rest[2] = 2'd3; rest[3] = 2'd2;
        set_read(2'd2, 28'h400);
        slave_return(0, 32'hA0A0_0000);
        #1;
        checks++; if (ready !== 1'b1 || s_rreq !== 4'b0100) begin failures++; $display("FAIL pp_accept: got ready=%b rreq=%b want 1 0100", ready, s_rreq); end
        checks++; if (rvalid !== 1'b1 || rdata !== 32'hA0A0_0000) begin failures++; $display("FAIL pp_data: got v=%b d=%h want 1 a0a00000", rvalid, rdata); end
        tick();
        rreq = 1'b0;
        s_rvalid = '0;
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL pp_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            slave_return(int'(rest[i]), 32'hB000_0000 + 32'(i));
            #1;
            checks++; if (rvalid !== 1'b1 || rdata !== 32'hB000_0000 + 32'(i)) begin failures++; $display("FAIL pp_drain%0d: got v=%b d=%h", i, rvalid, rdata); end
            tick();
        end
        s_rvalid = '0;
        #1;
        checks++; if (count !== 3'd0 || perr !== 1'b0) begin failures++; $display("FAIL pp_end: got count=%0d perr=%b want 0 0", count, perr); end
    endtask

    task automatic test_ready_stall();
        s_ready = 4'b1101;
        wreq  = 1'b1;
        rreq  = 1'b0;
        addr  = {2'd1, 28'h0ABCDEF};
        wdata = 32'hCAFEF00D;
        be    = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL stall%0d_ready: got %b want 0", i, ready); end
            tick();
        end
        s_ready = 4'b1111;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b want 1", ready); end
        checks++; if (s_wreq !== 4'b0010 || s_rreq !== 4'b0000) begin failures++; $display("FAIL stall_wreq: got w=%b r=%b want 0010 0000", s_wreq, s_rreq); end
        checks++; if (s_be !== 4'b0110 || s_wdata !== 32'hCAFEF00D || s_addr !== 28'h0ABCDEF) begin failures++; $display("FAIL stall_fields: got be=%b d=%h a=%h", s_be, s_wdata, s_addr); end
        tick();
        wreq = 1'b0;
        be   = 4'b1111;
    endtask

    task automatic test_async_reset();
        set_read(2'd1, 28'h500);
        tick();
        set_read(2'd2, 28'h501);
        tick();
        rreq = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL async_pre_count: got %0d want 2", count); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || perr !== 1'b0) begin failures++; $display("FAIL async_flush: got count=%0d perr=%b want 0 0", count, perr); end
        #1;
        reset = 1'b0;
        tick();
        set_read(2'd3, 28'h600);
        #1;
        checks++; if (ready !== 1'b1 || s_rreq !== 4'b1000) begin failures++; $display("FAIL async_next_req: got ready=%b rreq=%b want 1 1000", ready, s_rreq); end
        tick();
        rreq = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL async_next_count: got %0d want 1", count); end
        slave_return(3, 32'h7777_3333);
        #1;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h7777_3333) begin failures++; $display("FAIL async_next_data: got v=%b d=%h", rvalid, rdata); end
        tick();
        s_rvalid = '0;
        #1;
        checks++; if (count !== 3'd0 || perr !== 1'b0) begin failures++; $display("FAIL async_end: got count=%0d perr=%b want 0 0", count, perr); end
    endtask

    task automatic test_stray_empty();
        slave_return(1, 32'hBAD0_0001);
        #1;
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL stray_valid: got %b want 0", rvalid); end
        tick();
        s_rvalid = '0;
        tick();
        tick();
        checks++; if (perr !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL stray_sticky: got perr=%b count=%0d want 1 0", perr, count); end
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (perr !== 1'b0) begin failures++; $display("FAIL stray_cleared: got %b want 0", perr); end
    endtask

    initial begin
        reset    = 1'b1;
        addr     = '0;
        wdata    = '0;
        be       = 4'b1111;
        wreq     = 1'b0;
        rreq     = 1'b0;
        s_ready  = 4'b1111;
        s_rdata  = '0;
        s_rvalid = '0;
        test_reset();
        test_single_read();
        test_out_of_order();
        test_full_blocks_reads();
        test_full_push_pop();
        test_ready_stall();
        test_async_reset();
        test_stray_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
